pc_flow_ctrl: RTL and testbench
===============================

PC_FLOW_CTRL -- requirements
Module: pc_flow_ctrl

Interface
REQ-001 SHALL have ports: clk_i in 1, rising-edge clock; rst_i in 1, reset (synchronous, active-high).
REQ-002 SHALL have inputs: id_opcode_i 6 and id_funct_i 6, instruction in ID; id_rs_i 5 and id_rt_i 5, ID source registers; id_jump_tgt_i 32, j/jal/jr target resolved in ID.
REQ-003 SHALL have inputs: ex_opcode_i 6, opcode in EX (6'b000000 = bubble or R-type); ex_alu_zero_i 1; ex_mem_read_i 1, EX is a load; ex_rt_i 5, load destination; ex_branch_tgt_i 32.
REQ-004 SHALL have input imem_ready_i 1, pulse: instruction word for imem_addr_o valid this cycle.
REQ-005 SHALL have outputs: imem_addr_o 32, equal to the PC register; pc_select_o 2, 0 = PC+4, 1 = branch, 2 = jump, 3 never driven; ifid_write_o 1; ifid_flush_o 1; idex_flush_o 1.
REQ-006 SHALL have outputs: stall_cnt_o 16, load-use stall cycles; redirect_cnt_o 16, taken branches plus jumps.

Function
REQ-007 SHALL detect jump in ID: id_opcode_i 6'b000010 (j), 6'b000011 (jal), or 6'b000000 with id_funct_i 6'b001000 (jr).
REQ-008 SHALL take a branch in EX as follows: BEQ 6'b000100 when ex_alu_zero_i=1; BNE 6'b000101, BLEZ 6'b000110, BGTZ 6'b000111 when ex_alu_zero_i=0; every other opcode is not taken.
REQ-009 SHALL detect load-use: ex_mem_read_i=1, ex_rt_i!=0, and ex_rt_i equals id_rs_i or id_rt_i.
REQ-010 SHALL use event priority: EX taken branch > load-use > ID jump > sequential fetch.
REQ-011 SHALL ignore load-use and ID jump while an EX branch is taken, because the ID instruction is wrong-path.
REQ-012 SHALL ignore an ID jump during load-use; the held jump is acted on when the stall clears.
REQ-013 SHALL use an FSM with two states: RUN and DISCARD.
REQ-014 On a RUN taken branch: PC <= ex_branch_tgt_i; pc_select_o=1; ifid_flush_o=1; idex_flush_o=1; ifid_write_o=0.
REQ-015 On a RUN jump: PC <= id_jump_tgt_i; pc_select_o=2; ifid_flush_o=1; idex_flush_o=0.
REQ-016 On a redirect (REQ-014/015): if imem_ready_i=0 the state goes to DISCARD; else the state stays RUN.
REQ-017 On RUN load-use: PC holds; ifid_write_o=0 (IF/ID holds); idex_flush_o=1; a word returned the same cycle is dropped and the same address is refetched.
REQ-018 On RUN with no event: if imem_ready_i=1, PC <= PC+4 and ifid_write_o=1; else PC holds, ifid_flush_o=1 (bubble) and ifid_write_o=0.
REQ-019 In DISCARD: ifid_flush_o=1 and PC holds; on imem_ready_i=1 the returned word (old address) is dropped, PC is not incremented, and the state goes to RUN.
REQ-020 In DISCARD, a further taken branch or jump SHALL update PC to the new target with the REQ-014/015 flush outputs, and the state stays DISCARD until imem_ready_i=1.
REQ-021 In DISCARD, load-use SHALL assert idex_flush_o=1 and count a stall; PC holds.
REQ-022 Flush takes precedence over write: ifid_write_o=0 whenever ifid_flush_o=1.
REQ-023 pc_select_o SHALL be 0 whenever no redirect is issued this cycle.
REQ-024 PC arithmetic SHALL be 32-bit modulo: 32'hFFFFFFFC+4 = 0.
REQ-025 Branch and jump targets SHALL be loaded as given; bits [1:0] are not checked.
REQ-026 stall_cnt_o SHALL increment by 1 per load-use cycle, saturating at 16'hFFFF.
REQ-027 redirect_cnt_o SHALL increment by 1 per cycle issuing pc_select_o 1 or 2, saturating at 16'hFFFF.
REQ-028 The PC, the state and the counters SHALL be registered; the control outputs are combinational from the state and the inputs.

Reset
REQ-029 While rst_i=1 at a clk_i edge: PC <= 0; state <= RUN; both counters <= 0.
REQ-030 While rst_i=1: pc_select_o=0, ifid_write_o=0, ifid_flush_o=1, idex_flush_o=1, all independent of the other inputs.
REQ-031 Reset asserted in DISCARD or during a stall SHALL abandon the pending discard/stall; after release, the first imem_ready_i word is accepted at address 0.

Verification
REQ-032 Sequential: reset, then imem_ready_i=1 for 4 cycles -> imem_addr_o 0,4,8,12; ifid_write_o=1 each cycle; counters stay 0.
REQ-033 BEQ taken: ex_opcode_i=6'b000100, zero=1, tgt=32'h40, ready=1 -> next PC 32'h40; pc_select_o=1; both flushes=1; redirect_cnt_o=1. With zero=0 -> PC+4 and pc_select_o=0.
REQ-034 Load-use: ex_mem_read_i=1, ex_rt_i=5, id_rs_i=5, plus a jr in ID -> PC holds; idex_flush_o=1; pc_select_o=0; stall_cnt_o=1. Next cycle with hazard cleared: pc_select_o=2.
REQ-035 Priority: BNE taken (zero=0) and j in ID in the same cycle -> pc_select_o=1, PC <= ex_branch_tgt_i, redirect_cnt_o increments by 1 only.
REQ-036 Discard: j to 32'h100 with ready=0 -> DISCARD, 2 idle cycles with ifid_flush_o=1; ready=1 -> word dropped, PC stays 32'h100, RUN; next ready -> PC 32'h104.
REQ-037 Saturation: force 65536 load-use cycles -> stall_cnt_o holds 16'hFFFF.

Source files
------------

// File: rtl/pc_flow_ctrl_if.sv
// Fetch-control bundle between the PC flow controller and the pipeline.
// The master side is the controller; the slave side is the pipeline/imem.
interface pc_flow_ctrl_if;
  logic [5:0]  id_opcode_i;
  logic [5:0]  id_funct_i;
  logic [4:0]  id_rs_i;
  logic [4:0]  id_rt_i;
  logic [31:0] id_jump_tgt_i;
  logic [5:0]  ex_opcode_i;
  logic        ex_alu_zero_i;
  logic        ex_mem_read_i;
  logic [4:0]  ex_rt_i;
  logic [31:0] ex_branch_tgt_i;
  logic        imem_ready_i;
  logic [31:0] imem_addr_o;
  logic [1:0]  pc_select_o;
  logic        ifid_write_o;
  logic        ifid_flush_o;
  logic        idex_flush_o;
  logic [15:0] stall_cnt_o;
  logic [15:0] redirect_cnt_o;

  modport master (
    input  id_opcode_i, id_funct_i, id_rs_i, id_rt_i, id_jump_tgt_i,
    input  ex_opcode_i, ex_alu_zero_i, ex_mem_read_i, ex_rt_i, ex_branch_tgt_i,
    input  imem_ready_i,
    output imem_addr_o, pc_select_o, ifid_write_o, ifid_flush_o, idex_flush_o,
    output stall_cnt_o, redirect_cnt_o
  );

  modport slave (
    output id_opcode_i, id_funct_i, id_rs_i, id_rt_i, id_jump_tgt_i,
    output ex_opcode_i, ex_alu_zero_i, ex_mem_read_i, ex_rt_i, ex_branch_tgt_i,
    output imem_ready_i,
    input  imem_addr_o, pc_select_o, ifid_write_o, ifid_flush_o, idex_flush_o,
    input  stall_cnt_o, redirect_cnt_o
  );
endinterface

// File: rtl/pc_flow_ctrl.sv
// PC sequencing, branch/jump redirect, load-use stall and wrong-path word discard
// for a five-stage pipeline fetching from an instruction memory with variable latency.
module pc_flow_ctrl (
  input  logic          clk_i,
  input  logic          rst_i,
  pc_flow_ctrl_if.master bus
);

  typedef enum logic {RUN, DISCARD} state_t;

  localparam logic [1:0] SEL_SEQ    = 2'd0;
  localparam logic [1:0] SEL_BRANCH = 2'd1;
  localparam logic [1:0] SEL_JUMP   = 2'd2;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] stall_cnt_q, redirect_cnt_q;
  logic        stall_inc, redirect_inc;
  logic [1:0]  pc_select;
  logic        ifid_write, ifid_flush, idex_flush;
  logic        id_jump, ex_taken, load_use;

  assign id_jump = (bus.id_opcode_i == 6'b000010) || (bus.id_opcode_i == 6'b000011) ||
                   ((bus.id_opcode_i == 6'b000000) && (bus.id_funct_i == 6'b001000));

  always_comb begin
    ex_taken = 1'b0;
    case (bus.ex_opcode_i)
      6'b000100: ex_taken = bus.ex_alu_zero_i;
      6'b000101,
      6'b000110,
      6'b000111: ex_taken = ~bus.ex_alu_zero_i;
      default:   ex_taken = 1'b0;
    endcase
  end

  assign load_use = bus.ex_mem_read_i && (bus.ex_rt_i != 5'd0) &&
                    ((bus.ex_rt_i == bus.id_rs_i) || (bus.ex_rt_i == bus.id_rt_i));

  // Priority: EX branch beats load-use beats ID jump; a jump held behind a stall is seen again later.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pc_select    = SEL_SEQ;
    ifid_write   = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    stall_inc    = 1'b0;
    redirect_inc = 1'b0;
    if (rst_i) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (ex_taken) begin
            pc_d         = bus.ex_branch_tgt_i;
            pc_select    = SEL_BRANCH;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            redirect_inc = 1'b1;
            state_d      = bus.imem_ready_i ? RUN : DISCARD;
          end else if (load_use) begin
            idex_flush = 1'b1;
            stall_inc  = 1'b1;
          end else if (id_jump) begin
            pc_d         = bus.id_jump_tgt_i;
            pc_select    = SEL_JUMP;
            ifid_flush   = 1'b1;
            redirect_inc = 1'b1;
            state_d      = bus.imem_ready_i ? RUN : DISCARD;
          end else if (bus.imem_ready_i) begin
            pc_d       = pc_q + 32'd4;
            ifid_write = 1'b1;
          end else begin
            ifid_flush = 1'b1;
          end
        end
        DISCARD: begin
          // The in-flight word belongs to a stale address and is always dropped.
          ifid_flush = 1'b1;
          if (ex_taken) begin
            pc_d         = bus.ex_branch_tgt_i;
            pc_select    = SEL_BRANCH;
            idex_flush   = 1'b1;
            redirect_inc = 1'b1;
          end else if (load_use) begin
            idex_flush = 1'b1;
            stall_inc  = 1'b1;
          end else if (id_jump) begin
            pc_d         = bus.id_jump_tgt_i;
            pc_select    = SEL_JUMP;
            redirect_inc = 1'b1;
          end
          if (bus.imem_ready_i) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= RUN;
      pc_q           <= 32'd0;
      stall_cnt_q    <= 16'd0;
      redirect_cnt_q <= 16'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (stall_inc && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (redirect_inc && (redirect_cnt_q != 16'hFFFF))
        redirect_cnt_q <= redirect_cnt_q + 16'd1;
    end
  end

  assign bus.imem_addr_o    = pc_q;
  assign bus.pc_select_o    = pc_select;
  assign bus.ifid_write_o   = ifid_write;
  assign bus.ifid_flush_o   = ifid_flush;
  assign bus.idex_flush_o   = idex_flush;
  assign bus.stall_cnt_o    = stall_cnt_q;
  assign bus.redirect_cnt_o = redirect_cnt_q;

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Directed self-checking bench for pc_flow_ctrl: sequential fetch, branch/jump
// priority, load-use stall, discard state, PC wrap, reset abandonment, counter saturation.
module tb_pc_flow_ctrl;

  logic clk_i = 1'b0;
  logic rst_i;
  int   compared   = 0;
  int   mismatched = 0;

  pc_flow_ctrl_if bus ();

  pc_flow_ctrl dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.master)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.id_opcode_i     = 6'd0;
    bus.id_funct_i      = 6'd0;
    bus.id_rs_i         = 5'd0;
    bus.id_rt_i         = 5'd0;
    bus.id_jump_tgt_i   = 32'd0;
    bus.ex_opcode_i     = 6'd0;
    bus.ex_alu_zero_i   = 1'b0;
    bus.ex_mem_read_i   = 1'b0;
    bus.ex_rt_i         = 5'd0;
    bus.ex_branch_tgt_i = 32'd0;
    bus.imem_ready_i    = 1'b0;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic apply_stimulus_jump(input logic [5:0] op, input logic [31:0] tgt, input logic ready);
    clear_inputs();
    bus.id_opcode_i   = op;
    bus.id_jump_tgt_i = tgt;
    bus.imem_ready_i  = ready;
    settle();
  endtask

  initial begin
    clear_inputs();
    rst_i = 1'b1;
    // Reset outputs must ignore a taken branch and a ready word.
    bus.ex_opcode_i     = 6'b000100;
    bus.ex_alu_zero_i   = 1'b1;
    bus.ex_branch_tgt_i = 32'h40;
    bus.imem_ready_i    = 1'b1;
    step();
    step();
    check_output("rst_sel",      bus.pc_select_o, 32'd0);
    check_output("rst_write",    bus.ifid_write_o, 32'd0);
    check_output("rst_ifflush",  bus.ifid_flush_o, 32'd1);
    check_output("rst_exflush",  bus.idex_flush_o, 32'd1);
    check_output("rst_pc",       bus.imem_addr_o, 32'd0);
    check_output("rst_stall",    bus.stall_cnt_o, 32'd0);
    check_output("rst_redir",    bus.redirect_cnt_o, 32'd0);

    rst_i = 1'b0;
    clear_inputs();
    bus.imem_ready_i = 1'b1;
    settle();
    for (int i = 0; i < 4; i++) begin
      check_output("seq_pc",    bus.imem_addr_o, 32'(4 * i));
      check_output("seq_write", bus.ifid_write_o, 32'd1);
      check_output("seq_sel",   bus.pc_select_o, 32'd0);
      step();
    end
    check_output("seq_pc_end", bus.imem_addr_o, 32'd16);
    check_output("seq_stall",  bus.stall_cnt_o, 32'd0);
    check_output("seq_redir",  bus.redirect_cnt_o, 32'd0);

    // BEQ taken
    bus.ex_opcode_i = 6'b000100; bus.ex_alu_zero_i = 1'b1; bus.ex_branch_tgt_i = 32'h40;
    settle();
    check_output("beq_sel",     bus.pc_select_o, 32'd1);
    check_output("beq_ifflush", bus.ifid_flush_o, 32'd1);
    check_output("beq_exflush", bus.idex_flush_o, 32'd1);
    check_output("beq_write",   bus.ifid_write_o, 32'd0);
    step();
    check_output("beq_pc",    bus.imem_addr_o, 32'h40);
    check_output("beq_redir", bus.redirect_cnt_o, 32'd1);
    // BEQ not taken
    bus.ex_alu_zero_i = 1'b0;
    settle();
    check_output("beqnt_sel",   bus.pc_select_o, 32'd0);
    check_output("beqnt_write", bus.ifid_write_o, 32'd1);
    step();
    check_output("beqnt_pc", bus.imem_addr_o, 32'h44);

    // Load-use with jr held in ID
    clear_inputs();
    bus.ex_mem_read_i = 1'b1; bus.ex_rt_i = 5'd5; bus.id_rs_i = 5'd5;
    bus.id_opcode_i = 6'b000000; bus.id_funct_i = 6'b001000; bus.id_jump_tgt_i = 32'h200;
    bus.imem_ready_i = 1'b1;
    settle();
    check_output("lu_sel",     bus.pc_select_o, 32'd0);
    check_output("lu_exflush", bus.idex_flush_o, 32'd1);
    check_output("lu_write",   bus.ifid_write_o, 32'd0);
    check_output("lu_ifflush", bus.ifid_flush_o, 32'd0);
    step();
    check_output("lu_pc",    bus.imem_addr_o, 32'h44);
    check_output("lu_stall", bus.stall_cnt_o, 32'd1);
    bus.ex_mem_read_i = 1'b0;
    settle();
    check_output("jr_sel",     bus.pc_select_o, 32'd2);
    check_output("jr_ifflush", bus.ifid_flush_o, 32'd1);
    check_output("jr_exflush", bus.idex_flush_o, 32'd0);
    step();
    check_output("jr_pc",    bus.imem_addr_o, 32'h200);
    check_output("jr_redir", bus.redirect_cnt_o, 32'd2);

    // BNE taken and j in ID together: branch wins, one redirect counted
    clear_inputs();
    bus.ex_opcode_i = 6'b000101; bus.ex_alu_zero_i = 1'b0; bus.ex_branch_tgt_i = 32'h80;
    bus.id_opcode_i = 6'b000010; bus.id_jump_tgt_i = 32'h300; bus.imem_ready_i = 1'b1;
    settle();
    check_output("prio_sel", bus.pc_select_o, 32'd1);
    step();
    check_output("prio_pc",    bus.imem_addr_o, 32'h80);
    check_output("prio_redir", bus.redirect_cnt_o, 32'd3);

    // j to 0x100 with no word ready enters DISCARD
    apply_stimulus_jump(6'b000010, 32'h100, 1'b0);
    check_output("dj_sel", bus.pc_select_o, 32'd2);
    step();
    check_output("dj_pc",    bus.imem_addr_o, 32'h100);
    check_output("dj_redir", bus.redirect_cnt_o, 32'd4);
    clear_inputs();
    settle();
    for (int i = 0; i < 2; i++) begin
      check_output("dis_ifflush", bus.ifid_flush_o, 32'd1);
      check_output("dis_write",   bus.ifid_write_o, 32'd0);
      check_output("dis_sel",     bus.pc_select_o, 32'd0);
      step();
    end
    bus.imem_ready_i = 1'b1;
    settle();
    check_output("dis_drop_flush", bus.ifid_flush_o, 32'd1);
    check_output("dis_drop_write", bus.ifid_write_o, 32'd0);
    step();
    check_output("dis_drop_pc", bus.imem_addr_o, 32'h100);
    check_output("run_write",   bus.ifid_write_o, 32'd1);
    step();
    check_output("run_pc", bus.imem_addr_o, 32'h104);

    // PC wraps modulo 2^32
    apply_stimulus_jump(6'b000011, 32'hFFFF_FFFC, 1'b1);
    step();
    check_output("wrap_tgt", bus.imem_addr_o, 32'hFFFF_FFFC);
    clear_inputs();
    bus.imem_ready_i = 1'b1;
    step();
    check_output("wrap_pc",    bus.imem_addr_o, 32'd0);
    check_output("wrap_redir", bus.redirect_cnt_o, 32'd5);

    // Load-use then a further branch while in DISCARD
    apply_stimulus_jump(6'b000010, 32'h500, 1'b0);
    step();
    clear_inputs();
    bus.ex_mem_read_i = 1'b1; bus.ex_rt_i = 5'd3; bus.id_rt_i = 5'd3;
    settle();
    check_output("dlu_exflush", bus.idex_flush_o, 32'd1);
    check_output("dlu_ifflush", bus.ifid_flush_o, 32'd1);
    step();
    check_output("dlu_stall", bus.stall_cnt_o, 32'd2);
    check_output("dlu_pc",    bus.imem_addr_o, 32'h500);
    clear_inputs();
    bus.ex_opcode_i = 6'b000111; bus.ex_branch_tgt_i = 32'h600;
    settle();
    check_output("dbr_sel",     bus.pc_select_o, 32'd1);
    check_output("dbr_exflush", bus.idex_flush_o, 32'd1);
    step();
    check_output("dbr_pc",    bus.imem_addr_o, 32'h600);
    check_output("dbr_redir", bus.redirect_cnt_o, 32'd7);
    clear_inputs();
    bus.imem_ready_i = 1'b1;
    settle();
    check_output("dbr_drop_write", bus.ifid_write_o, 32'd0);
    step();
    check_output("dbr_hold_pc", bus.imem_addr_o, 32'h600);
    step();
    check_output("dbr_next_pc", bus.imem_addr_o, 32'h604);

    // Reset while in DISCARD abandons it
    apply_stimulus_jump(6'b000010, 32'h700, 1'b0);
    step();
    rst_i = 1'b1;
    clear_inputs();
    step();
    rst_i = 1'b0;
    bus.imem_ready_i = 1'b1;
    settle();
    check_output("rd_write", bus.ifid_write_o, 32'd1);
    check_output("rd_pc",    bus.imem_addr_o, 32'd0);
    check_output("rd_redir", bus.redirect_cnt_o, 32'd0);
    step();
    check_output("rd_next_pc", bus.imem_addr_o, 32'd4);

    // A load to r0 is never a hazard
    bus.ex_mem_read_i = 1'b1; bus.ex_rt_i = 5'd0; bus.id_rs_i = 5'd0;
    settle();
    check_output("r0_write",   bus.ifid_write_o, 32'd1);
    check_output("r0_exflush", bus.idex_flush_o, 32'd0);

    // Stall counter saturation
    clear_inputs();
    bus.ex_mem_read_i = 1'b1; bus.ex_rt_i = 5'd5; bus.id_rs_i = 5'd5; bus.imem_ready_i = 1'b1;
    for (int i = 0; i < 65534; i++) step();
    check_output("sat_pre", bus.stall_cnt_o, 32'h0000_FFFE);
    step();
    check_output("sat_max", bus.stall_cnt_o, 32'h0000_FFFF);
    step();
    step();
    check_output("sat_hold", bus.stall_cnt_o, 32'h0000_FFFF);
    check_output("sat_pc",   bus.imem_addr_o, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
